emmc_blk_arb: RTL and testbench
===============================

// Module: emmc_blk_arb
// PURPOSE
//  Round-robin arbiter and sequencer sharing the eMMC block engine (emmc_sm byte interface) among N_REQ clients.
//  Grants one client per single-block transfer, issues start/we to the engine, muxes write data and demuxes read data/strobes.
//  Counts BLK_BYTES data beats, waits for engine ready, signals done/err to the client; watchdog aborts stalled grants.
//  Sits between application clients and emmc_sm; all signals in the single system clock domain.
// PARAMETERS
//  N_REQ      2       number of requesters (1..8)
//  BLK_BYTES  512     data beats per transfer; must match engine blksize
//  TMO_CYC    65535   max cycles without a data beat or ready while granted; counter width $clog2(TMO_CYC+1)
// PORTS
//  clk_i         in   1         system clock
//  rst_n_i       in   1         reset; synchronous, active-low
//  req_i         in   N_REQ     per-client transfer request; level, held until done_o/err_o
//  we_req_i      in   N_REQ     per-client direction, 1=write block, 0=read block; sampled at grant
//  wdat_i        in   8*N_REQ   per-client write byte, client k on [8k+7:8k]
//  gnt_o         out  N_REQ     one-hot grant; held from grant to completion
//  rdat_o        out  8         read byte, shared by all clients (valid with own dvalid_o bit)
//  dvalid_o      out  N_REQ     per-client beat strobe: write byte consumed / read byte valid
//  done_o        out  N_REQ     1-cycle pulse, transfer completed
//  err_o         out  N_REQ     1-cycle pulse, transfer aborted by watchdog
//  sm_start_o    out  1         start pulse to engine
//  sm_we_o       out  1         direction to engine, valid with sm_start_o
//  sm_dat_o      out  8         write byte to engine = wdat_i of granted client (0 when idle)
//  sm_dat_i      in   8         read byte from engine
//  sm_dvalid_i   in   1         engine beat strobe (tx read or rx write)
//  sm_ready_i    in   1         engine idle and accepting a start
// BEHAVIOUR
//  Reset (rst_n_i=0 at clk edge): state IDLE, gnt_o/dvalid_o/done_o/err_o/sm_start_o/sm_we_o=0, rr pointer=0, beat and timeout counters=0.
//  FSM:
//   IDLE   : if |req_i && sm_ready_i -> pick winner, register gnt_o, latch we -> LAUNCH. else stay.
//   LAUNCH : sm_start_o=1, sm_we_o=latched we for exactly one cycle -> WAITLO.
//   WAITLO : wait sm_ready_i=0 (engine accepted) -> XFER; timeout -> ABORT.
//   XFER   : count sm_dvalid_i beats; when count==BLK_BYTES and sm_ready_i=1 -> DONE; timeout -> ABORT.
//   DONE   : done_o[g]=1 one cycle, gnt_o cleared, rr pointer=g+1 mod N_REQ -> IDLE.
//   ABORT  : err_o[g]=1 one cycle, gnt_o cleared, rr pointer=g+1 mod N_REQ -> IDLE.
//  Arbitration: scan clients starting at rr pointer, ascending with wrap; first with req_i=1 wins. Decision is registered, so gnt_o rises the cycle after IDLE sees the request.
//  Latency: req_i high in IDLE with engine ready -> gnt_o next cycle -> sm_start_o following cycle. Done->next grant >=2 cycles (DONE, IDLE).
//  Data path: sm_dat_o = wdat_i[g] combinationally while granted; rdat_o = sm_dat_i combinationally; dvalid_o[g] = sm_dvalid_i & granted & (count<BLK_BYTES), other bits 0.
//  Beat counter: width $clog2(BLK_BYTES+1); cleared on LAUNCH; saturates at BLK_BYTES; beats beyond BLK_BYTES are not forwarded and not counted.
//  sm_ready_i high in XFER before BLK_BYTES beats: keep waiting (no done); watchdog governs.
//  Watchdog: cleared on entering WAITLO, on every sm_dvalid_i beat and on sm_ready_i fall; increments otherwise in WAITLO/XFER; reaching TMO_CYC -> ABORT.
//  req_i of granted client dropping mid-transfer is ignored: engine cannot be cancelled, transfer runs to DONE/ABORT; done_o still pulses.
//  Request rising during a grant is held off until IDLE; simultaneous requests resolved by rr pointer only.
//  done_o/err_o never both set; at most one bit of gnt_o/done_o/err_o set at any time.
//  Reset mid-transfer: all outputs return to reset values next edge; engine is not reset by this block.
// TESTING
//  1. Reset, req_i=01, we_req_i=01, engine model ready -> gnt_o=01 next cycle, sm_start_o=1 & sm_we_o=1 one cycle later, 512 dvalid_o[0] beats, then done_o=01 one cycle.
//  2. req_i=11 held continuously, 4 reads -> grant order 0,1,0,1; each done_o pulse on the owning bit only; rdat_o matches engine bytes 0x00..0xFF pattern.
//  3. Engine stops strobing after 100 beats -> err_o[g]=1 exactly TMO_CYC cycles after last beat, gnt_o=0, next request granted normally.
//  4. Engine emits 515 beats -> only 512 dvalid_o beats forwarded; done_o after sm_ready_i returns high.
//  5. Granted client drops req_i at beat 10 -> transfer completes, done_o pulses; other client granted afterwards.
//  6. rst_n_i=0 at beat 200 -> next cycle gnt_o=0, sm_start_o=0, counters 0; req_i=10 after release -> client 1 granted (rr pointer 0 scan).

Source files
------------

// File: rtl/emmc_blk_arb.sv
// emmc_blk_arb: round-robin arbiter/sequencer sharing one eMMC block engine
// among N_REQ clients, one single-block transfer per grant.
// Ports:
//   clk_i, rst_n_i        system clock, synchronous active-low reset
//   req_i / we_req_i      per-client request level and direction (1=write)
//   wdat_i                per-client write byte, client k on [8k+7:8k]
//   gnt_o                 one-hot grant, held until completion
//   rdat_o / dvalid_o     shared read byte, per-client beat strobe
//   done_o / err_o        per-client completion / watchdog-abort pulses
//   sm_start_o, sm_we_o   start pulse and direction to the engine
//   sm_dat_o / sm_dat_i   write byte to / read byte from the engine
//   sm_dvalid_i           engine beat strobe
//   sm_ready_i            engine idle and accepting a start
module emmc_blk_arb #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned BLK_BYTES = 512,
  parameter int unsigned TMO_CYC   = 65535
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   we_req_i,
  input  logic [8*N_REQ-1:0] wdat_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [7:0]         rdat_o,
  output logic [N_REQ-1:0]   dvalid_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [N_REQ-1:0]   err_o,
  output logic               sm_start_o,
  output logic               sm_we_o,
  output logic [7:0]         sm_dat_o,
  input  logic [7:0]         sm_dat_i,
  input  logic               sm_dvalid_i,
  input  logic               sm_ready_i
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW = $clog2(BLK_BYTES + 1);
  localparam int unsigned TW = $clog2(TMO_CYC + 1);

  localparam logic [IW:0]   N_REQ_W  = (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [BW-1:0] BLK_W    = BW'(BLK_BYTES);
  localparam logic [TW-1:0] TMO_W    = TW'(TMO_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAITLO,
    S_XFER,
    S_DONE,
    S_ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic              we_q, we_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     wdog_q, wdog_d;
  logic              rdy_q;
  logic              start_q, start_d;
  logic              smwe_q, smwe_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW:0]       scan_sum;
  logic [IW-1:0]     scan_idx;
  logic              fwd;
  logic              wd_clr;
  logic [TW-1:0]     wdog_inc;
  logic [7:0]        wmux;

  // Round-robin scan starting at rr_q, ascending with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_q} + (IW+1)'(i);
      if (scan_sum >= N_REQ_W) scan_sum = scan_sum - N_REQ_W;
      scan_idx = scan_sum[IW-1:0];
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Write-data mux from the granted client; zero when nobody is granted.
  always_comb begin
    wmux = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) wmux = wmux | wdat_i[8*k +: 8];
    end
  end

  // Beats past the block size are dropped: neither forwarded nor counted.
  assign fwd      = sm_dvalid_i && (beat_q < BLK_W);
  assign wd_clr   = sm_dvalid_i || (rdy_q && !sm_ready_i);
  assign wdog_inc = wdog_q + TW'(1);

  assign sm_dat_o = wmux;
  assign rdat_o   = sm_dat_i;
  assign dvalid_o = gnt_q & {N_REQ{fwd}};

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    we_d    = we_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    wdog_d  = wdog_q;
    start_d = 1'b0;
    smwe_d  = 1'b0;
    done_d  = '0;
    err_d   = '0;

    if (fwd && (|gnt_q)) beat_d = beat_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if ((|req_i) && sm_ready_i) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gidx_d         = win_idx;
          we_d           = we_req_i[win_idx];
          state_d        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_d = 1'b1;
        smwe_d  = we_q;
        beat_d  = '0;
        wdog_d  = '0;
        state_d = S_WAITLO;
      end
      S_WAITLO: begin
        if (!sm_ready_i) begin
          wdog_d  = '0;
          state_d = S_XFER;
        end else if (wd_clr) begin
          wdog_d = '0;
        end else if (wdog_inc == TMO_W) begin
          err_d[gidx_q] = 1'b1;
          gnt_d         = '0;
          state_d       = S_ABORT;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_XFER: begin
        if ((beat_q == BLK_W) && sm_ready_i) begin
          done_d[gidx_q] = 1'b1;
          gnt_d          = '0;
          state_d        = S_DONE;
        end else if (wd_clr) begin
          wdog_d = '0;
        end else if (wdog_inc == TMO_W) begin
          err_d[gidx_q] = 1'b1;
          gnt_d         = '0;
          state_d       = S_ABORT;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_DONE, S_ABORT: begin
        rr_d    = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      we_q    <= 1'b0;
      rr_q    <= '0;
      beat_q  <= '0;
      wdog_q  <= '0;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      smwe_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      wdog_q  <= wdog_d;
      rdy_q   <= sm_ready_i;
      start_q <= start_d;
      smwe_q  <= smwe_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign sm_start_o = start_q;
  assign sm_we_o    = smwe_q;

endmodule

// File: tb/tb_emmc_blk_arb.sv
// tb_emmc_blk_arb: randomized bench for emmc_blk_arb with an inline engine
// model and a transaction-level round-robin reference.
module tb_emmc_blk_arb;

  localparam int unsigned N   = 3;
  localparam int unsigned BLK = 16;
  localparam int unsigned TMO = 40;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   we_req;
  logic [8*N-1:0] wdat;
  logic [N-1:0]   gnt;
  logic [7:0]     rdat;
  logic [N-1:0]   dvalid;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic           sm_start;
  logic           sm_we;
  logic [7:0]     sm_dat_o;
  logic [7:0]     sm_dat_i;
  logic           sm_dvalid;
  logic           sm_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int m_rr  = 0;

  emmc_blk_arb #(.N_REQ(N), .BLK_BYTES(BLK), .TMO_CYC(TMO)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .we_req_i   (we_req),
    .wdat_i     (wdat),
    .gnt_o      (gnt),
    .rdat_o     (rdat),
    .dvalid_o   (dvalid),
    .done_o     (done),
    .err_o      (err),
    .sm_start_o (sm_start),
    .sm_we_o    (sm_we),
    .sm_dat_o   (sm_dat_o),
    .sm_dat_i   (sm_dat_i),
    .sm_dvalid_i(sm_dvalid),
    .sm_ready_i (sm_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester scanning up from ptr with wrap.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  // Grant/done/err exclusivity on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      chk("excl", 32'({$onehot0(gnt), $onehot0(done | err), (gnt & (done | err)) == '0}), 32'd7);
  end

  // One transfer from grant to done/err, acting as the engine.
  task automatic xfer(input int nbeats, input int stall_at, input bit early,
                      input int drop_at, input bit do_rst);
    int         g;
    logic [N-1:0] oh;
    logic       wbit;
    int         early_evt;
    logic [7:0] b;
    g      = rr_pick(m_rr, req);
    oh     = '0;
    oh[g]  = 1'b1;
    wbit   = we_req[g];
    tick();
    chk("gnt", 32'(gnt), 32'(oh));
    chk("start_early", 32'(sm_start), 32'd0);
    tick();
    chk("start_we", 32'({sm_start, sm_we}), 32'({1'b1, wbit}));
    chk("gnt_hold", 32'(gnt), 32'(oh));
    tick();
    chk("start_1cyc", 32'(sm_start), 32'd0);
    sm_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      sm_dvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        #1;
        chk("gap_dv", 32'(dvalid), 32'd0);
        tick();
      end
      if (early && i == BLK / 2) begin
        sm_ready = 1'b1;
        tick();
        chk("early_rdy", 32'(done), 32'd0);
        sm_ready = 1'b0;
      end
      if (drop_at == i) req[g] = 1'b0;
      b         = 8'($urandom);
      wdat      = (8*N)'({$urandom, $urandom});
      sm_dat_i  = b;
      sm_dvalid = 1'b1;
      #1;
      chk("dvalid", 32'(dvalid), (i < BLK) ? 32'(oh) : 32'd0);
      chk("rdat", 32'(rdat), 32'(b));
      chk("sm_dat", 32'(sm_dat_o), 32'(wdat[g*8 +: 8]));
      if (do_rst && i == BLK / 2) begin
        rst_n = 1'b0;
        req   = '0;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ctl", 32'({done, err, sm_start, sm_we}), 32'd0);
        chk("rst_dv", 32'(dvalid), 32'd0);
        chk("rst_dat", 32'(sm_dat_o), 32'd0);
        rst_n     = 1'b1;
        sm_dvalid = 1'b0;
        sm_ready  = 1'b1;
        m_rr      = 0;
        tick();
        return;
      end
      tick();
      if (stall_at == i + 1) begin
        sm_dvalid = 1'b0;
        early_evt = 0;
        for (int k = 1; k < TMO; k++) begin
          tick();
          if (err != '0 || done != '0) early_evt++;
        end
        chk("wd_early", 32'(early_evt), 32'd0);
        tick();
        chk("err", 32'(err), 32'(oh));
        chk("gnt_clr_err", 32'(gnt), 32'd0);
        chk("no_done_err", 32'(done), 32'd0);
        m_rr     = (g + 1) % N;
        sm_ready = 1'b1;
        tick();
        chk("err_1cyc", 32'(err), 32'd0);
        return;
      end
    end
    sm_dvalid = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      tick();
      chk("done_wait", 32'(done), 32'd0);
    end
    sm_ready = 1'b1;
    tick();
    chk("done", 32'(done), 32'(oh));
    chk("gnt_clr", 32'(gnt), 32'd0);
    chk("err_none", 32'(err), 32'd0);
    m_rr = (g + 1) % N;
    tick();
    chk("done_1cyc", 32'(done), 32'd0);
  endtask

  initial begin
    int mode;
    rst_n     = 1'b0;
    req       = '0;
    we_req    = '0;
    wdat      = (8*N)'($urandom) | 1;
    sm_dat_i  = '0;
    sm_dvalid = 1'b0;
    sm_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ctl", 32'({done, err, sm_start, sm_we}), 32'd0);
    chk("rst_dv", 32'(dvalid), 32'd0);
    chk("rst_dat", 32'(sm_dat_o), 32'd0);
    rst_n = 1'b1;
    m_rr  = 0;
    tick();

    // Single write from client 0.
    req    = 3'b001;
    we_req = 3'b001;
    xfer(BLK, -1, 1'b0, -1, 1'b0);

    // Two clients held, back-to-back reads alternate.
    req    = 3'b011;
    we_req = 3'b000;
    repeat (4) xfer(BLK, -1, 1'b0, -1, 1'b0);

    // Randomized mix: plain, extra beats, early ready, request drop.
    for (int t = 0; t < 12; t++) begin
      req    = N'($urandom_range(1, (1 << N) - 1));
      we_req = N'($urandom);
      mode   = $urandom_range(0, 3);
      case (mode)
        0: xfer(BLK,     -1, 1'b0, -1, 1'b0);
        1: xfer(BLK + 3, -1, 1'b0, -1, 1'b0);
        2: xfer(BLK,     -1, 1'b1, -1, 1'b0);
        default: xfer(BLK, -1, 1'b0, $urandom_range(0, BLK - 1), 1'b0);
      endcase
    end

    // Engine stalls mid-block, then normal service resumes.
    req = 3'b100;
    xfer(BLK, 5, 1'b0, -1, 1'b0);
    req = 3'b011;
    xfer(BLK, -1, 1'b0, -1, 1'b0);

    // Reset mid-transfer, then client 1 alone wins from pointer 0.
    req = 3'b001;
    xfer(BLK, -1, 1'b0, -1, 1'b1);
    req    = 3'b010;
    we_req = N'($urandom);
    xfer(BLK, -1, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
